// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and per-GPR outstanding-write scoreboard for the 8x16-bit register file.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module regfile_wb_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned CNT_W   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*3-1:0]  req_dest,
   input  logic [NUM_REQ*16-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  alloc_valid,
   input  logic [2:0]            alloc_dest,
   output logic                  alloc_ready,
   output logic [7:0]            busy,
   output logic                  rf_wr,
   output logic                  rf_en,
   output logic [2:0]            rf_dest,
   output logic [15:0]           rf_data,
   input  logic                  rf_wr_success,
   output logic                  wr_err
);

   localparam int unsigned NumRegs = 8;
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic              found;
   int unsigned       win_idx;
   logic [2:0]        sel_dest;
   logic [15:0]       sel_data;

   logic              rf_wr_q;
   logic [2:0]        rf_dest_q;
   logic [15:0]       rf_data_q;
   logic              rf_en_q;
   logic              ack_pend_q;
   logic              wr_err_q;
   logic              ack_miss;
   logic              zero_wr;

   logic [CNT_W-1:0]  cnt_q [NumRegs];
   logic [CNT_W-1:0]  cnt_d [NumRegs];

`ifdef WB_RR_ARB_EN
   localparam int unsigned PtrW = (NUM_REQ > 2) ? 2 : 1;
   logic [PtrW-1:0] ptr_q, ptr_d;

   // Search starts at the pointer and wraps; first valid requester wins.
   always_comb begin
      found     = 1'b0;
      win_idx   = 0;
      req_ready = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         int unsigned idx;
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found          = 1'b1;
            win_idx        = idx;
            req_ready[idx] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = PtrW'((win_idx + 1) % NUM_REQ);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      found     = 1'b0;
      win_idx   = 0;
      req_ready = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[k]) begin
            found        = 1'b1;
            win_idx      = k;
            req_ready[k] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      sel_dest = '0;
      sel_data = '0;
      if (found) begin
         sel_dest = req_dest[win_idx*3 +: 3];
         sel_data = req_data[win_idx*16 +: 16];
      end
   end

   // Output stage never stalls: it is reloaded on every edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wr_q    <= 1'b0;
         rf_dest_q  <= '0;
         rf_data_q  <= '0;
         rf_en_q    <= 1'b0;
         ack_pend_q <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         rf_wr_q    <= found;
         rf_dest_q  <= sel_dest;
         rf_data_q  <= sel_data;
         rf_en_q    <= 1'b1;
         ack_pend_q <= rf_wr_q;
         if (ack_miss || zero_wr) begin
            wr_err_q <= 1'b1;
         end
      end
   end

   // A write leaving the stage retires one reservation, so a saturated counter can still accept.
   assign alloc_ready = (cnt_q[alloc_dest] != CntMax) || (rf_wr_q && (rf_dest_q == alloc_dest));
   assign zero_wr     = rf_wr_q && (cnt_q[rf_dest_q] == '0);
   assign ack_miss    = ack_pend_q && !rf_wr_success;

   always_comb begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
         logic inc, dec;
         inc      = alloc_valid && alloc_ready && (alloc_dest == 3'(r));
         dec      = rf_wr_q && (rf_dest_q == 3'(r)) && (cnt_q[r] != '0);
         cnt_d[r] = cnt_q[r];
         if (inc && !dec) begin
            cnt_d[r] = cnt_q[r] + 1'b1;
         end else if (dec && !inc) begin
            cnt_d[r] = cnt_q[r] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NumRegs; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < NumRegs; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
         busy[r] = (cnt_q[r] != '0);
      end
   end

   assign rf_wr   = rf_wr_q;
   assign rf_dest = rf_dest_q;
   assign rf_data = rf_data_q;
   assign rf_en   = rf_en_q;
   // A missing acknowledge is flagged in the very cycle it was due.
   assign wr_err  = wr_err_q | ack_miss;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; the register file's acknowledge is
// modelled by echoing rf_wr one cycle later while ack_en is set.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [8:0]  req_dest;
   logic [47:0] req_data;
   logic [2:0]  req_ready;
   logic        alloc_valid;
   logic [2:0]  alloc_dest;
   logic        alloc_ready;
   logic [7:0]  busy;
   logic        rf_wr;
   logic        rf_en;
   logic [2:0]  rf_dest;
   logic [15:0] rf_data;
   logic        rf_wr_success;
   logic        wr_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic ack_en   = 1'b1;

`ifdef WB_RR_ARB_EN
   localparam bit RrMode = 1'b1;
`else
   localparam bit RrMode = 1'b0;
`endif

   regfile_wb_arbiter #(.NUM_REQ(3), .CNT_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_dest      (req_dest),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .alloc_valid   (alloc_valid),
      .alloc_dest    (alloc_dest),
      .alloc_ready   (alloc_ready),
      .busy          (busy),
      .rf_wr         (rf_wr),
      .rf_en         (rf_en),
      .rf_dest       (rf_dest),
      .rf_data       (rf_data),
      .rf_wr_success (rf_wr_success),
      .wr_err        (wr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      logic prev;
      prev = rf_wr;
      @(posedge clk);
      #1;
      rf_wr_success = ack_en & prev;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      req_valid     = '0;
      req_dest      = '0;
      req_data      = '0;
      alloc_valid   = 1'b0;
      alloc_dest    = '0;
      rf_wr_success = 1'b0;
      ack_en        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      req_valid     = '0;
      req_dest      = '0;
      req_data      = '0;
      alloc_valid   = 1'b0;
      alloc_dest    = '0;
      rf_wr_success = 1'b0;
      #2;
      n_checks++; if (rf_wr !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wr got %b want 0", rf_wr); end
      n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL reset_rf_en got %b want 0", rf_en); end
      n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy got %h want 00", busy); end
      n_checks++; if (rf_dest !== 3'd0 || rf_data !== 16'h0) begin
         n_fail++; $display("FAIL reset_rf_bus got %0d/%h want 0/0000", rf_dest, rf_data); end
      n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL rf_en_before_edge got %b want 0", rf_en); end
      tick();
      n_checks++; if (rf_en !== 1'b1) begin n_fail++; $display("FAIL rf_en_after_edge got %b want 1", rf_en); end
   endtask

   task automatic test_basic_write();
      do_reset();
      alloc_valid = 1'b1;
      alloc_dest  = 3'd3;
      #1;
      n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_alloc_ready got %b want 1", alloc_ready); end
      tick();
      alloc_valid = 1'b0;
      req_valid   = 3'b001;
      req_dest    = {3'd0, 3'd0, 3'd3};
      req_data    = {16'h0, 16'h0, 16'h1234};
      #1;
      n_checks++; if (busy !== 8'h08) begin n_fail++; $display("FAIL basic_busy_set got %h want 08", busy); end
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL basic_grant got %b want 001", req_ready); end
      tick();
      req_valid = '0;
      #1;
      n_checks++; if (rf_wr !== 1'b1 || rf_dest !== 3'd3 || rf_data !== 16'h1234) begin
         n_fail++; $display("FAIL basic_rf_out got wr=%b dest=%0d data=%h want 1/3/1234", rf_wr, rf_dest, rf_data); end
      n_checks++; if (busy !== 8'h08) begin n_fail++; $display("FAIL basic_busy_hold got %h want 08", busy); end
      tick();
      n_checks++; if (busy !== 8'h00 || rf_wr !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy_clear got busy=%h wr=%b want 00/0", busy, rf_wr); end
      tick();
      n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err got %b want 0", wr_err); end
   endtask

   task automatic test_arbitration();
      logic [2:0] exp_g;
      int         prev_idx;
      do_reset();
      req_dest  = '0;
      req_data  = {16'hA002, 16'hA001, 16'hA000};
      prev_idx  = -1;
      for (int c = 0; c < 6; c++) begin
         req_valid = 3'b111;
         #1;
         exp_g = RrMode ? 3'(1 << (c % 3)) : 3'b001;
         n_checks++; if (req_ready !== exp_g) begin
            n_fail++; $display("FAIL arb_grant_c%0d got %b want %b", c, req_ready, exp_g); end
         if (prev_idx >= 0) begin
            n_checks++; if (rf_wr !== 1'b1 || rf_data !== 16'hA000 + 16'(prev_idx)) begin
               n_fail++; $display("FAIL arb_data_c%0d got wr=%b data=%h want 1/%h", c, rf_wr, rf_data,
                                  16'hA000 + 16'(prev_idx)); end
         end
         prev_idx = RrMode ? (c % 3) : 0;
         tick();
      end
      req_valid = '0;
      #1;
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL arb_idle got %b want 000", req_ready); end
      n_checks++; if (rf_data !== 16'hA000 + 16'(prev_idx)) begin
         n_fail++; $display("FAIL arb_last_data got %h want %h", rf_data, 16'hA000 + 16'(prev_idx)); end
   endtask

   task automatic test_alloc_saturation();
      do_reset();
      alloc_dest = 3'd5;
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1;
         #1;
         n_checks++; if (alloc_ready !== 1'b1) begin
            n_fail++; $display("FAIL sat_alloc%0d got %b want 1", i, alloc_ready); end
         tick();
      end
      #1;
      n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full got %b want 0", alloc_ready); end
      req_valid = 3'b001;
      req_dest  = {3'd0, 3'd0, 3'd5};
      req_data  = {16'h0, 16'h0, 16'h5555};
      tick();
      req_valid = '0;
      #1;
      n_checks++; if (rf_wr !== 1'b1 || alloc_ready !== 1'b1) begin
         n_fail++; $display("FAIL sat_same_cycle got wr=%b ready=%b want 1/1", rf_wr, alloc_ready); end
      tick();
      #1;
      n_checks++; if (alloc_ready !== 1'b0 || busy !== 8'h20) begin
         n_fail++; $display("FAIL sat_still_full got ready=%b busy=%h want 0/20", alloc_ready, busy); end
      alloc_valid = 1'b0;
      req_valid   = 3'b001;
      tick();
      tick();
      tick();
      req_valid = '0;
      #1;
      n_checks++; if (rf_wr !== 1'b1 || busy !== 8'h20) begin
         n_fail++; $display("FAIL sat_drain_last got wr=%b busy=%h want 1/20", rf_wr, busy); end
      tick();
      n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL sat_drained got %h want 00", busy); end
      tick();
      n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL sat_wr_err got %b want 0", wr_err); end
   endtask

   task automatic test_zero_count_write();
      do_reset();
      req_valid = 3'b001;
      req_dest  = {3'd0, 3'd0, 3'd2};
      req_data  = {16'h0, 16'h0, 16'h00FF};
      tick();
      req_valid = '0;
      #1;
      n_checks++; if (rf_wr !== 1'b1 || rf_dest !== 3'd2 || rf_data !== 16'h00FF) begin
         n_fail++; $display("FAIL zero_written got wr=%b dest=%0d data=%h want 1/2/00ff", rf_wr, rf_dest, rf_data); end
      tick();
      n_checks++; if (wr_err !== 1'b1 || busy !== 8'h00) begin
         n_fail++; $display("FAIL zero_err got err=%b busy=%h want 1/00", wr_err, busy); end
      tick();
      tick();
      n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL zero_sticky got %b want 1", wr_err); end
      do_reset();
      n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL zero_cleared got %b want 0", wr_err); end
   endtask

   task automatic test_ack_missing();
      do_reset();
      alloc_valid = 1'b1;
      alloc_dest  = 3'd1;
      tick();
      alloc_valid = 1'b0;
      ack_en      = 1'b0;
      req_valid   = 3'b010;
      req_dest    = {3'd0, 3'd1, 3'd0};
      req_data    = {16'h0, 16'hBEEF, 16'h0};
      #1;
      n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL ack_grant got %b want 010", req_ready); end
      tick();
      req_valid = '0;
      #1;
      n_checks++; if (rf_wr !== 1'b1 || wr_err !== 1'b0) begin
         n_fail++; $display("FAIL ack_t1 got wr=%b err=%b want 1/0", rf_wr, wr_err); end
      tick();
      #1;
      n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL ack_t2 got %b want 1", wr_err); end
      ack_en = 1'b1;
      tick();
      n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL ack_sticky got %b want 1", wr_err); end
   endtask

   task automatic test_async_reset();
      do_reset();
      alloc_valid = 1'b1;
      alloc_dest  = 3'd4;
      tick();
      alloc_dest  = 3'd6;
      tick();
      alloc_valid = 1'b0;
      req_valid   = 3'b001;
      req_dest    = {3'd0, 3'd0, 3'd4};
      req_data    = {16'h0, 16'h0, 16'hCAFE};
      tick();
      req_valid = '0;
      #1;
      n_checks++; if (rf_wr !== 1'b1 || busy !== 8'h50) begin
         n_fail++; $display("FAIL arst_pre got wr=%b busy=%h want 1/50", rf_wr, busy); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (rf_wr !== 1'b0 || rf_dest !== 3'd0 || rf_data !== 16'h0) begin
         n_fail++; $display("FAIL arst_rf got wr=%b dest=%0d data=%h want 0/0/0000", rf_wr, rf_dest, rf_data); end
      n_checks++; if (busy !== 8'h00 || rf_en !== 1'b0 || wr_err !== 1'b0) begin
         n_fail++; $display("FAIL arst_state got busy=%h en=%b err=%b want 00/0/0", busy, rf_en, wr_err); end
      @(posedge clk);
      #1;
      rst           = 1'b0;
      rf_wr_success = 1'b0;
      alloc_valid   = 1'b1;
      alloc_dest    = 3'd7;
      req_valid     = 3'b001;
      req_dest      = {3'd0, 3'd0, 3'd7};
      req_data      = {16'h0, 16'h0, 16'h5A5A};
      #1;
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL arst_grant got %b want 001", req_ready); end
      tick();
      alloc_valid = 1'b0;
      req_valid   = '0;
      #1;
      n_checks++; if (rf_wr !== 1'b1 || rf_dest !== 3'd7 || rf_data !== 16'h5A5A || rf_en !== 1'b1) begin
         n_fail++; $display("FAIL arst_first_write got wr=%b dest=%0d data=%h en=%b want 1/7/5a5a/1",
                            rf_wr, rf_dest, rf_data, rf_en); end
      tick();
      tick();
      n_checks++; if (wr_err !== 1'b0 || busy !== 8'h00) begin
         n_fail++; $display("FAIL arst_after got err=%b busy=%h want 0/00", wr_err, busy); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_arbitration();
      test_alloc_saturation();
      test_zero_count_write();
      test_ack_missing();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 8×16-bit GPR file. It accepts write requests from up to NUM_REQ execution sources (ALU, load, JAL/JALR link) and grants one per cycle. It drives the register file's single write port through a registered stage and tracks in-flight writes per register so decode can detect RAW/WAW hazards.

## Interface
Parameters:
- NUM_REQ, 3 — number of write requesters (2..4); index 0 has highest fixed priority.
- CNT_W, 2 — width of each per-register outstanding-write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_dest  in  NUM_REQ×3  destination GPR per requester.
- req_data  in  NUM_REQ×16  write data per requester.
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- alloc_valid  in  1  decode reserves a future write to alloc_dest.
- alloc_dest  in  3  GPR being reserved.
- alloc_ready  out  1  reservation accepted this cycle.
- busy  out  8  bit r set while counter[r] ≠ 0.
- rf_wr  out  1  register-file write strobe.
- rf_en  out  1  register-file read enable; constant 1 out of reset.
- rf_dest  out  3  register-file write destination.
- rf_data  out  16  register-file write data.
- rf_wr_success  in  1  register-file acknowledge, one cycle after rf_wr.
- wr_err  out  1  sticky: acknowledge missing, or write to a register with counter = 0.

## Operation
- Grant logic is combinational. Among asserted req_valid bits, exactly one req_ready is asserted. No req_ready is asserted when no req_valid is set.
- Selection without the macro: lowest index wins.
- The winning request is captured into the output stage (rf_wr, rf_dest, rf_data) at the clock edge. The stage is overwritten every cycle and never stalls, so grants never back-pressure.
- Scoreboard: one CNT_W-bit counter per GPR.
  - An accepted alloc increments counter[alloc_dest].
  - A write leaving the output stage (rf_wr = 1) decrements counter[rf_dest].
- alloc_ready = 0 when counter[alloc_dest] is at maximum (3). The request is then ignored and decode must retry.
- Increment and decrement of the same register in the same cycle leave the counter unchanged. This case is also allowed at maximum: alloc_ready = 1 when a decrement of that register occurs that cycle.
- A write to a register whose counter is 0:
  - The data is still written.
  - The counter stays at 0, with no underflow.
  - wr_err is set.
- The acknowledge check: rf_wr in cycle T requires rf_wr_success = 1 in T+1; otherwise wr_err is set. wr_err is cleared only by rst.
- Reset values (applied asynchronously):
  - rf_wr = 0, rf_dest = 0, rf_data = 0, wr_err = 0.
  - All counters = 0, so busy = 0.
  - Round-robin pointer = 0.
  - rf_en = 0 while rst is asserted, 1 from the first edge after deassertion.
- Reset mid-operation: an in-flight output-stage write is discarded and pending ack checks are cancelled.

## Timing
- Grant is combinational: req_ready[i] in the same cycle T as req_valid[i].
- rf_wr/rf_dest/rf_data are registered and valid in T+1.
- The register file updates at the end of T+1; rf_wr_success is sampled in T+2.
- busy[r] falls in the cycle after rf_wr for the last outstanding write to r, i.e. T+2 relative to the grant.
- An alloc in cycle T shows busy[r] = 1 from T+1.
- Sustained throughput is one write per cycle with no bubbles.

## Configuration
- WB_RR_ARB_EN defined: round-robin arbitration.
  - The pointer holds the index searched first.
  - After a grant to index g, the pointer becomes (g+1) mod NUM_REQ.
  - The pointer is unchanged when no grant is made.
- WB_RR_ARB_EN undefined: fixed priority, index 0 highest. No pointer state is built.

## Test plan
- Reset, then alloc R3 and write R3 = 0x1234 from req 0 → busy[3] = 1 next cycle; rf_wr = 1, rf_dest = 3, rf_data = 0x1234 one cycle after the grant; busy[3] = 0 afterwards; wr_err = 0.
- All three requesters held valid for 6 cycles:
  - With WB_RR_ARB_EN, grant order is 0,1,2,0,1,2.
  - Without it, req 0 is granted every cycle.
- Alloc R5 three times, then a fourth alloc → alloc_ready = 0 on the fourth. Repeat the fourth alloc in the same cycle rf_wr targets R5 → alloc_ready = 1 and the counter stays at 3.
- Write to R2 with its counter at 0 → rf_data = 0x00FF is still written, the counter stays at 0, and wr_err = 1 until rst.
- Hold rf_wr_success = 0 after an rf_wr → wr_err = 1 two cycles after the grant.
- Assert rst asynchronously mid-cycle with 2 allocs pending and rf_wr = 1 → all outputs reach their reset values immediately, without waiting for a clock edge; after release, the first request is granted normally.
